regfile_mp: RTL and testbench



---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_mp_if.sv | 31 +++
 rtl/regfile_scoreboard.sv | 48 ++++
 rtl/regfile_mp.sv | 97 +++++++++
 tb/tb_regfile_mp.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-read-port register file.
package regfile_pkg;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   localparam int XLEN_DEF = 32;
   localparam int NREG_DEF = 32;
   localparam int NRD_DEF  = 2;
   localparam int REG_ZERO = 0;

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write/issue bundle between decode-issue, writeback and the register file.
interface regfile_mp_if
   import regfile_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int NREG = NREG_DEF,
   parameter int NRD  = NRD_DEF
);
   localparam int AW = $clog2(NREG);

   logic [NRD*AW-1:0]   ra;
   logic [NRD*XLEN-1:0] rdata;
   logic [NRD-1:0]      rbusy;
   logic                we;
   logic [AW-1:0]       wa;
   logic [XLEN-1:0]     wd;
   logic                iss_en;
   logic [AW-1:0]       iss_addr;
   logic                ready;

   modport master (
      output ra, we, wa, wd, iss_en, iss_addr,
      input  rdata, rbusy, ready
   );

   modport slave (
      input  ra, we, wa, wd, iss_en, iss_addr,
      output rdata, rbusy, ready
   );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write busy bits with issue-over-writeback priority and registered per-port lookups.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREG = NREG_DEF,
   parameter int NRD  = NRD_DEF,
   parameter int AW   = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              we,
   input  logic [AW-1:0]     wa,
   input  logic              iss_en,
   input  logic [AW-1:0]     iss_addr,
   input  logic [NRD*AW-1:0] ra,
   output logic [NRD-1:0]    rbusy
);

   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_nx;

   // Issue is applied after the write-clear so a same-cycle re-issue keeps the bit set.
   always_comb begin
      busy_nx = busy;
      if (we && (wa != AW'(REG_ZERO))) begin
         busy_nx[wa] = 1'b0;
      end
      if (iss_en && (iss_addr != AW'(REG_ZERO))) begin
         busy_nx[iss_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy  <= '0;
         rbusy <= '0;
      end else if (en) begin
         busy <= busy_nx;
         for (int p = 0; p < NRD; p++) begin
            rbusy[p] <= busy_nx[ra[p*AW +: AW]];
         end
      end else begin
         rbusy <= '0;
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file: x0 hardwired, write-to-read bypass, post-reset clear sweep.
//
//   state | meaning
//   CLEAR | zeroing mem[idx] one register per cycle; inputs ignored, outputs held 0
//   RUN   | normal read/write/issue operation, ready high
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int NREG = NREG_DEF,
   parameter int NRD  = NRD_DEF
) (
   input logic         clk,
   input logic         reset,
   regfile_mp_if.slave bus
);

   localparam int AW = $clog2(NREG);

   localparam logic [0:0] S_CLEAR = CLEAR;
   localparam logic [0:0] S_RUN   = RUN;

   logic [XLEN-1:0] mem [NREG];
   logic [0:0]      state;
   logic [AW-1:0]   idx;
   logic            ready_q;
   logic            run;
   logic            wr_en;
   logic [XLEN-1:0] rd_next [NRD];
   logic [XLEN-1:0] rdata_q [NRD];

   assign run   = (state == S_RUN);
   assign wr_en = run && bus.we && (bus.wa != AW'(REG_ZERO));

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_CLEAR;
         idx     <= '0;
         ready_q <= 1'b0;
      end else if (state == S_CLEAR) begin
         idx <= idx + AW'(1);
         if (idx == AW'(NREG - 1)) begin
            state   <= S_RUN;
            ready_q <= 1'b1;
         end
      end
   end

   // Storage holds its contents while reset is asserted; the sweep clears it afterwards.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (!run) begin
            mem[idx] <= '0;
         end else if (wr_en) begin
            mem[bus.wa] <= bus.wd;
         end
      end
   end

   for (genvar p = 0; p < NRD; p++) begin : g_rd
      logic [AW-1:0] ra_p;
      assign ra_p       = bus.ra[p*AW +: AW];
      assign rd_next[p] = (ra_p == AW'(REG_ZERO))       ? '0     :
                          (bus.we && (bus.wa == ra_p))  ? bus.wd :
                                                          mem[ra_p];
      assign bus.rdata[p*XLEN +: XLEN] = rdata_q[p];
   end

   always_ff @(posedge clk) begin
      for (int p = 0; p < NRD; p++) begin
         if (reset || !run) begin
            rdata_q[p] <= '0;
         end else begin
            rdata_q[p] <= rd_next[p];
         end
      end
   end

   regfile_scoreboard #(
      .NREG (NREG),
      .NRD  (NRD),
      .AW   (AW)
   ) u_scoreboard (
      .clk      (clk),
      .reset    (reset),
      .en       (run),
      .we       (bus.we),
      .wa       (bus.wa),
      .iss_en   (bus.iss_en),
      .iss_addr (bus.iss_addr),
      .ra       (bus.ra),
      .rbusy    (bus.rbusy)
   );

   assign bus.ready = ready_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: driver pushes model expectations, monitor compares after each edge.
module tb_regfile_mp;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int NRD  = 2;

   typedef struct {
      logic [NRD*XLEN-1:0] rd;
      logic [NRD-1:0]      rb;
      logic                rdy;
   } exp_t;

   logic clk = 1'b0;
   logic reset;

   regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus ();

   regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   exp_t        exp_q[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc    = 0;

   logic [XLEN-1:0] m_mem [NREG];
   bit   [NREG-1:0] m_busy;
   int              sweep_left = NREG;

   // One clock of stimulus; the expected post-edge outputs come from the register-file rules.
   task automatic step(input bit rst, input bit w, input logic [4:0] wa_i, input logic [31:0] wd_i,
                       input bit is, input logic [4:0] ia, input logic [4:0] r0, input logic [4:0] r1);
      exp_t e;
      logic [4:0] ra_a [NRD];
      @(negedge clk);
      reset        = rst;
      bus.we       = w;
      bus.wa       = wa_i;
      bus.wd       = wd_i;
      bus.iss_en   = is;
      bus.iss_addr = ia;
      bus.ra       = {r1, r0};
      ra_a[0] = r0;
      ra_a[1] = r1;
      e.rd  = '0;
      e.rb  = '0;
      e.rdy = 1'b0;
      if (rst) begin
         sweep_left = NREG;
         m_busy     = '0;
         for (int i = 0; i < NREG; i++) m_mem[i] = '0;
      end else if (sweep_left > 0) begin
         sweep_left--;
         e.rdy = (sweep_left == 0);
      end else begin
         e.rdy = 1'b1;
         for (int p = 0; p < NRD; p++) begin
            if (ra_a[p] == 5'd0)              e.rd[p*XLEN +: XLEN] = '0;
            else if (w && wa_i == ra_a[p])    e.rd[p*XLEN +: XLEN] = wd_i;
            else                              e.rd[p*XLEN +: XLEN] = m_mem[ra_a[p]];
         end
         if (w && wa_i != 5'd0) begin
            m_mem[wa_i]  = wd_i;
            m_busy[wa_i] = 1'b0;
         end
         if (is && ia != 5'd0) m_busy[ia] = 1'b1;
         for (int p = 0; p < NRD; p++) e.rb[p] = m_busy[ra_a[p]];
      end
      exp_q.push_back(e);
   endtask

   task automatic idle_read(input logic [4:0] r0, input logic [4:0] r1);
      step(0, 0, 5'd0, 32'h0, 0, 5'd0, r0, r1);
   endtask

   always begin
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         for (int p = 0; p < NRD; p++) begin
            checks++;
            if (bus.rdata[p*XLEN +: XLEN] !== e.rd[p*XLEN +: XLEN]) begin
               errors++;
               $display("FAIL rdata%0d cyc=%0d got=%h exp=%h", p, cyc,
                        bus.rdata[p*XLEN +: XLEN], e.rd[p*XLEN +: XLEN]);
            end
         end
         checks++;
         if (bus.rbusy !== e.rb) begin
            errors++;
            $display("FAIL rbusy cyc=%0d got=%b exp=%b", cyc, bus.rbusy, e.rb);
         end
         checks++;
         if (bus.ready !== e.rdy) begin
            errors++;
            $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, bus.ready, e.rdy);
         end
      end
   end

   initial begin
      logic [4:0]  a, b, c, d;
      logic [31:0] v;
      reset        = 1'b1;
      bus.we       = 1'b0;
      bus.wa       = '0;
      bus.wd       = '0;
      bus.iss_en   = 1'b0;
      bus.iss_addr = '0;
      bus.ra       = '0;

      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      // Sweep: random writes/issues must be ignored, outputs stay 0 until ready.
      for (int i = 0; i < NREG; i++)
         step(0, 1, 5'($urandom), $urandom, 1, 5'($urandom), 5'($urandom), 5'($urandom));

      // x0 is hardwired and never busy
      step(0, 1, 5'd0, 32'hDEADBEEF, 0, 5'd0, 5'd0, 5'd0);
      step(0, 0, 5'd0, 32'h0, 1, 5'd0, 5'd0, 5'd0);
      idle_read(5'd0, 5'd0);

      // bypass on both ports
      step(0, 1, 5'd5, 32'h12345678, 0, 5'd0, 5'd5, 5'd5);
      idle_read(5'd5, 5'd5);

      // scoreboard set then writeback clear
      step(0, 0, 5'd0, 32'h0, 1, 5'd7, 5'd0, 5'd0);
      idle_read(5'd7, 5'd7);
      step(0, 1, 5'd7, 32'h000000A5, 0, 5'd0, 5'd7, 5'd7);
      idle_read(5'd7, 5'd0);

      // issue and write to the same register in one cycle
      step(0, 1, 5'd9, 32'h00000055, 1, 5'd9, 5'd9, 5'd0);
      idle_read(5'd9, 5'd9);

      // reset in the middle of operation drops busy bits and clears storage
      step(0, 1, 5'd3, 32'h00000077, 1, 5'd3, 5'd0, 5'd0);
      idle_read(5'd3, 5'd3);
      step(1, 0, 0, 0, 0, 0, 5'd3, 5'd3);
      for (int i = 0; i < NREG; i++) idle_read(5'd3, 5'd3);
      idle_read(5'd3, 5'd3);

      // randomized traffic concentrated on a few registers, with rare resets
      for (int i = 0; i < 500; i++) begin
         a = 5'($urandom_range(0, 7));
         b = 5'($urandom_range(0, 7));
         c = 5'($urandom_range(0, 7));
         d = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         v = $urandom;
         step(($urandom_range(0, 249) == 0), ($urandom_range(0, 1) == 1), a, v,
              ($urandom_range(0, 2) == 0), b, c, d);
      end

      // preload everything, pulse reset, then every register must read zero
      for (int i = 0; i < NREG; i++) idle_read(5'd0, 5'd0);
      for (int i = 1; i < NREG; i++) step(0, 1, 5'(i), $urandom | 32'h1, 1, 5'(i), 5'(i), 5'd0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < NREG; i++) idle_read(5'($urandom), 5'($urandom));
      for (int i = 0; i < NREG; i++) idle_read(5'(i), 5'(NREG - 1 - i));

      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
